// File: rtl/core_debug_ctrl.sv
// Run/step/halt controller with PC breakpoint and retired-instruction counter,
// plus a scrollable hex-nibble window over selectable probe channels.
module core_debug_ctrl #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DIGITS = 6,
  parameter int unsigned PC_W   = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CH*DATA_W-1:0]      probe_bus,
  input  logic [PC_W-1:0]               pc,
  input  logic [$clog2(NUM_CH+1)-1:0]   ch_sel,
  input  logic                          run_btn,
  input  logic                          step_btn,
  input  logic                          halt_btn,
  input  logic                          scroll_btn,
  input  logic                          bp_en,
  input  logic [PC_W-1:0]               bp_addr,
  output logic                          core_en,
  output logic                          halted,
  output logic                          bp_hit,
  output logic [DATA_W-1:0]             retired,
  output logic [DIGITS*4-1:0]           digits
);

  localparam int unsigned CH_W     = $clog2(NUM_CH + 1);
  localparam int unsigned WIN_BITS = 4 * DIGITS;
  localparam int unsigned NWIN     = (DATA_W + WIN_BITS - 1) / WIN_BITS;
  localparam int unsigned WIN_W    = (NWIN > 1) ? $clog2(NWIN) : 1;
  localparam int unsigned EXT_W    = NWIN * WIN_BITS;

  typedef enum logic [1:0] {ST_HALT, ST_RUN, ST_STEP} state_t;

  state_t              state_q;
  logic                skip_q;
  logic                bp_hit_q;
  logic [DATA_W-1:0]   retired_q;
  logic [3:0]          sync1_q, sync2_q, prev_q, pulse_q;
  logic                run_p, step_p, halt_p, scroll_p;
  logic                match;
  logic [CH_W-1:0]     ch_q;
  logic [WIN_W-1:0]    win_q, win_d;
  logic [DATA_W-1:0]   sel_word;
  logic [EXT_W-1:0]    word_ext;
  logic [DIGITS*4-1:0] digits_q, digits_d;

  // Button order in the vectors: {scroll, halt, step, run}
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      pulse_q <= '0;
    end else begin
      sync1_q <= {scroll_btn, halt_btn, step_btn, run_btn};
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      pulse_q <= sync2_q & ~prev_q;
    end
  end

  assign run_p    = pulse_q[0];
  assign step_p   = pulse_q[1];
  assign halt_p   = pulse_q[2];
  assign scroll_p = pulse_q[3];

  // skip lets a run resume from the breakpoint PC without re-matching
  assign match   = bp_en && (pc == bp_addr) && (state_q == ST_RUN) && !skip_q;
  assign core_en = (state_q == ST_STEP) || ((state_q == ST_RUN) && !match);
  assign halted  = (state_q == ST_HALT);
  assign bp_hit  = bp_hit_q;
  assign retired = retired_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_HALT;
      skip_q    <= 1'b0;
      bp_hit_q  <= 1'b0;
      retired_q <= '0;
    end else begin
      if (core_en) retired_q <= retired_q + DATA_W'(1);
      if (run_p || step_p) bp_hit_q <= 1'b0;
      case (state_q)
        ST_HALT: begin
          if (!halt_p) begin
            if (step_p) begin
              state_q <= ST_STEP;
            end else if (run_p) begin
              state_q <= ST_RUN;
              skip_q  <= 1'b1;
            end
          end
        end
        ST_STEP: state_q <= ST_HALT;
        ST_RUN: begin
          skip_q <= 1'b0;
          if (halt_p) begin
            state_q <= ST_HALT;
          end else if (match) begin
            state_q  <= ST_HALT;
            bp_hit_q <= 1'b1;
          end
        end
        default: state_q <= ST_HALT;
      endcase
    end
  end

  always_comb begin
    sel_word = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (ch_sel == CH_W'(i)) sel_word = probe_bus[i*DATA_W +: DATA_W];
    end
    if (ch_sel == CH_W'(NUM_CH)) sel_word = retired_q;
  end

  // Channel change resets the window and overrides a concurrent scroll
  always_comb begin
    win_d = win_q;
    if (ch_sel != ch_q) begin
      win_d = '0;
    end else if (scroll_p) begin
      win_d = (win_q == WIN_W'(NWIN - 1)) ? '0 : win_q + WIN_W'(1);
    end
  end

  // Zero-extended word makes nibbles beyond DATA_W read as 0
  assign word_ext = EXT_W'(sel_word);

  always_comb begin
    digits_d = '0;
    for (int d = 0; d < int'(DIGITS); d++) begin
      digits_d[d*4 +: 4] = word_ext[(int'(win_q) * int'(DIGITS) + d) * 4 +: 4];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ch_q     <= '0;
      win_q    <= '0;
      digits_q <= '0;
    end else begin
      ch_q     <= ch_sel;
      win_q    <= win_d;
      digits_q <= digits_d;
    end
  end

  assign digits = digits_q;

endmodule

// File: tb/tb_core_debug_ctrl.sv
// Directed bench for core_debug_ctrl: stepping, breakpoints, button priority
// and the probe display window, with a tiny PC model standing in for the core.
module tb_core_debug_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] probe_bus;
  logic [31:0]  pc;
  logic [2:0]   ch_sel;
  logic         run_btn, step_btn, halt_btn, scroll_btn;
  logic         bp_en;
  logic [31:0]  bp_addr;
  logic         core_en, halted, bp_hit;
  logic [31:0]  retired;
  logic [23:0]  digits;

  int n_tests = 0;
  int n_fail  = 0;

  core_debug_ctrl #(.NUM_CH(4), .DATA_W(32), .DIGITS(6), .PC_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .probe_bus  (probe_bus),
    .pc         (pc),
    .ch_sel     (ch_sel),
    .run_btn    (run_btn),
    .step_btn   (step_btn),
    .halt_btn   (halt_btn),
    .scroll_btn (scroll_btn),
    .bp_en      (bp_en),
    .bp_addr    (bp_addr),
    .core_en    (core_en),
    .halted     (halted),
    .bp_hit     (bp_hit),
    .retired    (retired),
    .digits     (digits)
  );

  always #5 clk = ~clk;

  // Core stand-in: PC advances by one instruction on each enabled edge
  always @(posedge clk) begin
    if (rst) pc <= 32'h0;
    else if (core_en) pc <= pc + 32'd4;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic press(input int which, input int hold);
    @(negedge clk);
    case (which)
      0: run_btn = 1'b1;
      1: step_btn = 1'b1;
      2: halt_btn = 1'b1;
      default: scroll_btn = 1'b1;
    endcase
    repeat (hold) @(negedge clk);
    run_btn = 1'b0; step_btn = 1'b0; halt_btn = 1'b0; scroll_btn = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int en_cnt, bad, nrun;
    logic seen_run, done;
    logic [31:0] pc_save;

    rst = 1'b1;
    run_btn = 1'b0; step_btn = 1'b0; halt_btn = 1'b0; scroll_btn = 1'b0;
    bp_en = 1'b0; bp_addr = 32'h0; ch_sel = 3'd0; probe_bus = '0;
    repeat (3) @(negedge clk);
    check("rst_core_en", core_en, 0);
    check("rst_halted", halted, 1);
    check("rst_bp_hit", bp_hit, 0);
    check("rst_retired", retired, 0);
    check("rst_digits", digits, 0);
    rst = 1'b0;

    // Step button held five cycles: one enabled cycle only
    @(negedge clk);
    step_btn = 1'b1;
    en_cnt = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (i == 4) step_btn = 1'b0;
      if (core_en) en_cnt++;
    end
    check("step_en_cycles", 64'(en_cnt), 1);
    check("step_retired", retired, 1);
    check("step_halted", halted, 1);
    check("step_pc", pc, 32'h4);

    // Run into a breakpoint at 0x10
    bp_en = 1'b1; bp_addr = 32'h10;
    press(0, 2);
    seen_run = 1'b0; done = 1'b0; bad = 0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (pc == 32'h10 && core_en) bad++;
      if (!halted) seen_run = 1'b1;
      else if (seen_run) done = 1'b1;
    end
    check("bp_reached", done, 1);
    check("bp_no_exec_at_bp", 64'(bad), 0);
    check("bp_hit_set", bp_hit, 1);
    check("bp_retired", retired, 4);
    check("bp_pc", pc, 32'h10);
    check("bp_core_en", core_en, 0);

    // Resume from the breakpoint PC
    press(0, 2);
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (!halted) done = 1'b1;
    end
    check("resume_started", done, 1);
    check("resume_core_en", core_en, 1);
    check("resume_bp_cleared", bp_hit, 0);
    repeat (4) @(negedge clk);
    check("resume_still_run", halted, 0);
    check("resume_pc_past_bp", pc > 32'h10, 1);

    // Halt button
    press(2, 2);
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (halted) done = 1'b1;
    end
    check("halt_reached", done, 1);
    @(negedge clk);
    check("halt_core_en", core_en, 0);
    check("halt_retired_vs_pc", retired, pc >> 2);

    // Run, step and halt together from HALT: halt wins
    pc_save = pc;
    @(negedge clk);
    run_btn = 1'b1; step_btn = 1'b1; halt_btn = 1'b1;
    en_cnt = 0; nrun = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (i == 4) begin run_btn = 1'b0; step_btn = 1'b0; halt_btn = 1'b0; end
      if (core_en) en_cnt++;
      if (!halted) nrun++;
    end
    check("prio_core_en_cycles", 64'(en_cnt), 0);
    check("prio_not_halted_cycles", 64'(nrun), 0);
    check("prio_pc_unchanged", pc, pc_save);

    // Display window over probe channels
    probe_bus = {32'h0, 32'hCAFEF00D, 32'hDEADBEEF, 32'h12345678};
    ch_sel = 3'd1;
    repeat (3) @(negedge clk);
    check("disp_ch1_win0", digits, 24'hADBEEF);
    press(3, 2);
    repeat (6) @(negedge clk);
    check("disp_ch1_win1", digits, 24'h0000DE);
    press(3, 2);
    repeat (6) @(negedge clk);
    check("disp_ch1_wrap", digits, 24'hADBEEF);
    press(3, 2);
    repeat (6) @(negedge clk);
    check("disp_ch1_win1_again", digits, 24'h0000DE);
    ch_sel = 3'd0;
    repeat (3) @(negedge clk);
    check("disp_chg_resets_win", digits, 24'h345678);
    ch_sel = 3'd5;
    repeat (3) @(negedge clk);
    check("disp_out_of_range", digits, 24'h0);
    ch_sel = 3'd2;
    repeat (3) @(negedge clk);
    check("disp_ch2", digits, 24'hFEF00D);

    // Retired counter as display channel after three steps
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int s = 0; s < 3; s++) begin
      press(1, 2);
      repeat (8) @(negedge clk);
    end
    check("steps3_retired", retired, 3);
    ch_sel = 3'd4;
    repeat (3) @(negedge clk);
    check("disp_retired", digits, 24'h000003);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
